// File: rtl/instr_host_packer_if.sv
// Host-word and instruction-buffer signal bundle for instr_host_packer.
// slave is the packer's view; master is the host/buffer side that drives it.
interface instr_host_packer_if #(
   parameter int HOST_WIDTH    = 16,
   parameter int INSTR_WIDTH   = 64,
   parameter int ERR_CNT_WIDTH = 8
);
   logic [HOST_WIDTH-1:0]    host_data;
   logic                     host_valid;
   logic                     host_sof;
   logic                     host_ready;
   logic                     buffer_full;
   logic [INSTR_WIDTH-1:0]   interface_input;
   logic                     instr_valid;
   logic [ERR_CNT_WIDTH-1:0] frame_err_count;
   logic                     busy;

   modport slave (
      input  host_data, host_valid, host_sof, buffer_full,
      output host_ready, interface_input, instr_valid, frame_err_count, busy
   );

   modport master (
      output host_data, host_valid, host_sof, buffer_full,
      input  host_ready, interface_input, instr_valid, frame_err_count, busy
   );
endinterface

// File: rtl/instr_host_packer.sv
// Packs BEATS framed host words (beat 0 in the LSBs) into one instruction for the
// instruction buffer, holding it under buffer_full and counting framing errors.
module instr_host_packer #(
   parameter int HOST_WIDTH    = 16,
   parameter int INSTR_WIDTH   = 64,
   parameter int ERR_CNT_WIDTH = 8
) (
   input logic                rst,
   input logic                external_clk,
   instr_host_packer_if.slave bus
);
   localparam int BEATS  = INSTR_WIDTH / HOST_WIDTH;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t                   r_state;
   state_t                   w_next_state;
   logic [BEAT_W-1:0]        r_beat;
   logic [INSTR_WIDTH-1:0]   r_assembly;
   logic [INSTR_WIDTH-1:0]   r_instr;
   logic                     r_instr_valid;
   logic [ERR_CNT_WIDTH-1:0] r_err_count;

   logic                     w_host_ready;
   logic                     w_busy;
   logic                     w_accept;
   logic                     w_store;
   logic                     w_frame_err;
   logic                     w_last;
   logic [BEAT_W-1:0]        w_slot;
   logic [INSTR_WIDTH-1:0]   w_assembled;

   // An SOF word always restarts at slot 0, discarding any partial instruction.
   always_comb begin
      // NOTE: every signal gets a value before any condition, so no latch is inferred.
      w_accept    = bus.host_valid && w_host_ready;
      w_slot      = bus.host_sof ? '0 : r_beat;
      w_store     = w_accept && (bus.host_sof || (r_beat != '0));
      w_frame_err = w_accept && (bus.host_sof == (r_beat != '0));
      w_last      = w_store && (w_slot == LAST_BEAT);
      w_assembled = bus.host_sof ? '0 : r_assembly;
      w_assembled[int'(w_slot) * HOST_WIDTH +: HOST_WIDTH] = bus.host_data;
   end

   always_ff @(posedge external_clk or posedge rst) begin
      if (rst) begin
         r_state <= COLLECT;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         COLLECT: if (w_last)           w_next_state = HOLD;
         HOLD:    if (!bus.buffer_full) w_next_state = COLLECT;
         default:                       w_next_state = COLLECT;
      endcase
   end

   // host_ready sees rst directly so the host is stalled while reset is held.
   always_comb begin
      w_host_ready = (r_state == COLLECT) && !rst;
      w_busy       = (r_beat != '0) || (r_state == HOLD);
   end

   always_ff @(posedge external_clk or posedge rst) begin
      if (rst) begin
         // NOTE: the assembly and output registers are reset too, so a reset drops any partial or pending instruction.
         r_beat        <= '0;
         r_assembly    <= '0;
         r_instr       <= '0;
         r_instr_valid <= 1'b0;
         r_err_count   <= '0;
      end else begin
         if (w_store) begin
            r_beat     <= w_last ? '0 : w_slot + BEAT_W'(1);
            r_assembly <= w_assembled;
         end
         if (w_last) begin
            r_instr       <= w_assembled;
            r_instr_valid <= 1'b1;
         end else if ((r_state == HOLD) && !bus.buffer_full) begin
            r_instr_valid <= 1'b0;
         end
         if (w_frame_err && (r_err_count != '1)) begin
            r_err_count <= r_err_count + ERR_CNT_WIDTH'(1);
         end
      end
   end

   assign bus.host_ready      = w_host_ready;
   assign bus.busy            = w_busy;
   assign bus.interface_input = r_instr;
   assign bus.instr_valid     = r_instr_valid;
   assign bus.frame_err_count = r_err_count;
endmodule

// File: tb/tb_instr_host_packer.sv
// Directed bench for instr_host_packer: vector table for framing/backpressure,
// hand sequences for counter saturation and asynchronous reset in HOLD.
module tb_instr_host_packer;
   logic external_clk = 1'b0;
   logic rst          = 1'b1;

   instr_host_packer_if bus ();

   instr_host_packer dut (
      .rst          (rst),
      .external_clk (external_clk),
      .bus          (bus)
   );

   always #5 external_clk = ~external_clk;

   typedef struct {
      logic        rst;
      logic        valid;
      logic        sof;
      logic [15:0] data;
      logic        bf;
      logic        exp_ready;
      logic        exp_valid;
      logic [63:0] exp_data;
      logic [7:0]  exp_err;
      logic        exp_busy;
   } vec_t;

   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   localparam logic [63:0] D1 = 64'h4444_3333_2222_1111;
   localparam logic [63:0] D3 = 64'hDEF0_9ABC_5678_1234;
   localparam logic [63:0] D4 = 64'h0004_0003_0002_0001;
   localparam logic [63:0] D5 = 64'h0F04_0F03_0F02_0F01;
   localparam logic [63:0] D6 = 64'h1004_1003_1002_1001;

   function automatic vec_t mk(input logic r, input logic v, input logic s,
                               input logic [15:0] d, input logic bf,
                               input logic er, input logic ev, input logic [63:0] ed,
                               input logic [7:0] ee, input logic eb);
      vec_t x;
      x.rst = r; x.valid = v; x.sof = s; x.data = d; x.bf = bf;
      x.exp_ready = er; x.exp_valid = ev; x.exp_data = ed;
      x.exp_err = ee; x.exp_busy = eb;
      return x;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle's inputs on the falling edge, settle before sampling.
   task automatic put(input logic v, input logic s, input logic [15:0] d, input logic bf);
      @(negedge external_clk);
      bus.host_valid  = v;
      bus.host_sof    = s;
      bus.host_data   = d;
      bus.buffer_full = bf;
      #1;
   endtask

   task automatic check_all(input string tag, input logic er, input logic ev,
                            input logic [63:0] ed, input logic [7:0] ee, input logic eb);
      check({tag, " host_ready"},      64'(bus.host_ready),      64'(er));
      check({tag, " instr_valid"},     64'(bus.instr_valid),     64'(ev));
      check({tag, " interface_input"}, bus.interface_input,      ed);
      check({tag, " frame_err_count"}, 64'(bus.frame_err_count), 64'(ee));
      check({tag, " busy"},            64'(bus.busy),            64'(eb));
   endtask

   task automatic pulse_reset();
      @(negedge external_clk);
      rst = 1'b1;
      #1;
      rst = 1'b0;
   endtask

   initial begin
      bus.host_valid  = 1'b0;
      bus.host_sof    = 1'b0;
      bus.host_data   = '0;
      bus.buffer_full = 1'b0;

      // Expected values describe the outputs seen before the edge that samples the row.
      vecs.push_back(mk(1, 0, 0, 16'h0000, 0,   0, 0, 64'h0, 0, 0));
      // Basic frame, no backpressure
      vecs.push_back(mk(0, 1, 1, 16'h1111, 0,   1, 0, 64'h0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 16'h2222, 0,   1, 0, 64'h0, 0, 1));
      vecs.push_back(mk(0, 1, 0, 16'h3333, 0,   1, 0, 64'h0, 0, 1));
      vecs.push_back(mk(0, 1, 0, 16'h4444, 0,   1, 0, 64'h0, 0, 1));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 0,   0, 1, D1,    0, 1));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 0,   1, 0, D1,    0, 0));
      // Same frame, buffer_full for 6 cycles; stray host_valid in HOLD is ignored
      vecs.push_back(mk(0, 1, 1, 16'h1111, 0,   1, 0, D1,    0, 0));
      vecs.push_back(mk(0, 1, 0, 16'h2222, 0,   1, 0, D1,    0, 1));
      vecs.push_back(mk(0, 1, 0, 16'h3333, 0,   1, 0, D1,    0, 1));
      vecs.push_back(mk(0, 1, 0, 16'h4444, 0,   1, 0, D1,    0, 1));
      for (int i = 0; i < 6; i++)
         vecs.push_back(mk(0, 1, 0, 16'hBEEF, 1, 0, 1, D1,   0, 1));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 0,   0, 1, D1,    0, 1));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 0,   1, 0, D1,    0, 0));
      // Stray non-SOF word in idle, then a good frame
      vecs.push_back(mk(0, 1, 0, 16'hDEAD, 0,   1, 0, D1,    0, 0));
      vecs.push_back(mk(0, 1, 1, 16'h1234, 0,   1, 0, D1,    1, 0));
      vecs.push_back(mk(0, 1, 0, 16'h5678, 0,   1, 0, D1,    1, 1));
      vecs.push_back(mk(0, 1, 0, 16'h9ABC, 0,   1, 0, D1,    1, 1));
      vecs.push_back(mk(0, 1, 0, 16'hDEF0, 0,   1, 0, D1,    1, 1));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 0,   0, 1, D3,    1, 1));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 0,   1, 0, D3,    1, 0));
      // Reset, then an SOF arriving mid-frame restarts assembly
      vecs.push_back(mk(1, 0, 0, 16'h0000, 0,   0, 0, 64'h0, 0, 0));
      vecs.push_back(mk(0, 1, 1, 16'hAAAA, 0,   1, 0, 64'h0, 0, 0));
      vecs.push_back(mk(0, 1, 0, 16'hBBBB, 0,   1, 0, 64'h0, 0, 1));
      vecs.push_back(mk(0, 1, 1, 16'h0001, 0,   1, 0, 64'h0, 0, 1));
      vecs.push_back(mk(0, 1, 0, 16'h0002, 0,   1, 0, 64'h0, 1, 1));
      vecs.push_back(mk(0, 1, 0, 16'h0003, 0,   1, 0, 64'h0, 1, 1));
      vecs.push_back(mk(0, 1, 0, 16'h0004, 0,   1, 0, 64'h0, 1, 1));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 0,   0, 1, D4,    1, 1));
      vecs.push_back(mk(0, 0, 0, 16'h0000, 0,   1, 0, D4,    1, 0));

      foreach (vecs[i]) begin
         @(negedge external_clk);
         rst             = vecs[i].rst;
         bus.host_valid  = vecs[i].valid;
         bus.host_sof    = vecs[i].sof;
         bus.host_data   = vecs[i].data;
         bus.buffer_full = vecs[i].bf;
         #1;
         check_all($sformatf("v%0d", i), vecs[i].exp_ready, vecs[i].exp_valid,
                   vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_busy);
      end

      // Framing-error counter saturation over 300 stray words
      pulse_reset();
      put(1, 0, 16'h5A5A, 0);
      repeat (254) @(posedge external_clk);
      #1 check("sat count 254", 64'(bus.frame_err_count), 64'd254);
      @(posedge external_clk);
      #1 check("sat count 255", 64'(bus.frame_err_count), 64'd255);
      repeat (45) @(posedge external_clk);
      #1 check("sat count hold", 64'(bus.frame_err_count), 64'd255);
      check("sat busy", 64'(bus.busy), 64'd0);
      put(0, 0, 16'h0000, 0);

      // Asynchronous reset while an instruction is held
      pulse_reset();
      put(1, 1, 16'h0F01, 1);
      put(1, 0, 16'h0F02, 1);
      put(1, 0, 16'h0F03, 1);
      put(1, 0, 16'h0F04, 1);
      put(0, 0, 16'h0000, 1);
      check_all("hold pre-rst", 0, 1, D5, 0, 1);
      @(posedge external_clk);
      #3 rst = 1'b1;
      #1 check_all("async rst", 0, 0, 64'h0, 0, 0);
      @(negedge external_clk);
      rst = 1'b0;
      bus.buffer_full = 1'b0;
      for (int i = 0; i < 3; i++) begin
         put(0, 0, 16'h0000, 0);
         check_all($sformatf("post-rst %0d", i), 1, 0, 64'h0, 0, 0);
      end
      put(1, 1, 16'h1001, 0);
      put(1, 0, 16'h1002, 0);
      put(1, 0, 16'h1003, 0);
      put(1, 0, 16'h1004, 0);
      put(0, 0, 16'h0000, 0);
      check_all("refill hold", 0, 1, D6, 0, 1);
      put(0, 0, 16'h0000, 0);
      check_all("refill done", 1, 0, D6, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
